// File: rtl/day01_sweep_ctrl_if.sv
// Candidate/verdict handshake between the sweep sequencer
// and the downstream seen-set checker.
interface day01_sweep_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              resp_valid;
    logic              resp_hit;

    modport master (
        output out_valid,
        output out_sum,
        input  out_ready,
        input  resp_valid,
        input  resp_hit
    );

    modport slave (
        input  out_valid,
        input  out_sum,
        output out_ready,
        output resp_valid,
        output resp_hit
    );
endinterface

// File: rtl/day01_sweep_ctrl.sv
// Day-01 part-2 sequencer: sweeps the ROM, streams running sums
// to the seen-set checker and stops on the first repeat.
module day01_sweep_ctrl #(
    parameter int ROM_DEPTH  = 973,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int MAX_PASSES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    day01_sweep_ctrl_if.master chk,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [DATA_W-1:0] result,
    output logic [15:0]       pass_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [15:0]       PMAX = 16'(MAX_PASSES);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        ISSUE,
        WAIT_RESP,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sum;
    logic [15:0]       r_pass;
    logic              r_found;
    logic [DATA_W-1:0] r_result;

    logic              w_valid;
    logic              w_busy;
    logic              w_done;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_sum;
    logic              w_hs;
    logic              w_go;
    logic              w_limit;

    assign w_add   = r_sum + rom_data;
    assign w_hs    = w_valid & chk.out_ready;
    assign w_go    = start & ~w_busy;
    assign w_limit = (r_pass == PMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The pass limit is only consulted after a miss, so a hit
    // on the final candidate still reports found.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) w_next = SEED;
            end
            SEED, ISSUE: begin
                if (w_hs) w_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (chk.resp_valid) begin
                    if (chk.resp_hit || w_limit) w_next = DONE;
                    else                         w_next = ISSUE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_sum   = '0;
        unique case (r_state)
            SEED: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
            end
            ISSUE: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                w_sum   = w_add;
            end
            WAIT_RESP: w_busy = 1'b1;
            DONE:      w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_sum    <= '0;
            r_pass   <= '0;
            r_found  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_go) begin
                r_addr  <= '0;
                r_sum   <= '0;
                r_pass  <= '0;
                r_found <= 1'b0;
            end
            if (r_state == ISSUE && w_hs) begin
                r_sum <= w_add;
                if (r_addr == LAST) begin
                    r_addr <= '0;
                    if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            if (r_state == WAIT_RESP && chk.resp_valid) begin
                if (chk.resp_hit) begin
                    r_result <= r_sum;
                    r_found  <= 1'b1;
                end else begin
                    r_found  <= 1'b0;
                end
            end
        end
    end

    assign chk.out_valid = w_valid;
    assign chk.out_sum   = w_sum;
    assign rom_addr      = r_addr;
    assign rom_en        = w_busy;
    assign busy          = w_busy;
    assign done          = w_done;
    assign found         = r_found;
    assign result        = r_result;
    assign pass_count    = r_pass;

endmodule

// File: tb/tb_day01_sweep_ctrl.sv
// Bench for day01_sweep_ctrl: table of ROM images with a reference
// sum model feeding a scoreboard, plus a seen-set checker responder.
module tb_day01_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [63:0] rom_data;
    logic        busy;
    logic        done;
    logic        found;
    logic [63:0] result;
    logic [15:0] pass_count;

    logic [63:0] rom_mem [4];

    day01_sweep_ctrl_if #(.DATA_W(64)) u_if ();

    day01_sweep_ctrl #(
        .ROM_DEPTH  (4),
        .ADDR_W     (16),
        .DATA_W     (64),
        .MAX_PASSES (3)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .chk        (u_if),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .result     (result),
        .pass_count (pass_count)
    );

    assign rom_data = rom_mem[rom_addr[1:0]];

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] sb_q [$];
    bit          seen [logic [63:0]];
    bit          pend;
    bit          ph;
    logic [63:0] exp_sum;

    typedef struct {
        logic [3:0][63:0] d;
        int               n;
        bit               f;
        logic [63:0]      res;
        logic [15:0]      pc;
        logic [15:0]      ad;
    } vec_t;

    vec_t tbl [5];

    function automatic void chk(string nm, logic [63:0] got,
                                logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    function automatic vec_t mk(logic [63:0] a, logic [63:0] b,
                                logic [63:0] c, logic [63:0] e,
                                int n, bit f, logic [63:0] r,
                                logic [15:0] pc, logic [15:0] ad);
        vec_t v;
        v.d[0] = a;
        v.d[1] = b;
        v.d[2] = c;
        v.d[3] = e;
        v.n    = n;
        v.f    = f;
        v.res  = r;
        v.pc   = pc;
        v.ad   = ad;
        return v;
    endfunction

    // Seen-set checker: answers one negedge after acceptance.
    initial begin
        u_if.resp_valid = 1'b0;
        u_if.resp_hit   = 1'b0;
        pend = 1'b0;
        ph   = 1'b0;
        forever begin
            @(negedge clk);
            u_if.resp_valid = 1'b0;
            u_if.resp_hit   = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                u_if.resp_valid = 1'b1;
                u_if.resp_hit   = ph;
                pend = 1'b0;
            end else if (u_if.out_valid && u_if.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_candidate: got %0h expected none",
                             u_if.out_sum);
                end else begin
                    exp_sum = sb_q.pop_front();
                    chk("out_sum", u_if.out_sum, exp_sum);
                end
                ph = seen.exists(u_if.out_sum);
                seen[u_if.out_sum] = 1'b1;
                pend = 1'b1;
            end
            if (rst_n && start && !busy) seen.delete();
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic load(vec_t v);
        logic [63:0] s;
        for (int i = 0; i < 4; i++) rom_mem[i] = v.d[i];
        s = '0;
        for (int i = 0; i < v.n; i++) begin
            sb_q.push_back(s);
            s = s + v.d[i % 4];
        end
    endtask

    task automatic wait_cond(string nm, int which);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge clk);
            #1;
            unique case (which)
                0: hit = done;
                1: hit = u_if.out_valid && rom_addr == 16'd2;
                2: hit = u_if.out_valid && rom_addr == 16'd3;
                default: hit = busy && !u_if.out_valid;
            endcase
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL %s: got timeout expected event", nm);
        end
    endtask

    task automatic run_vec(vec_t v, bit bp, bit bstart);
        logic [63:0] hs;
        logic [15:0] ha;
        load(v);
        pulse_start();
        if (bp) begin
            wait_cond("bp_wait", 1);
            u_if.out_ready = 1'b0;
            hs = u_if.out_sum;
            ha = rom_addr;
            repeat (5) begin
                @(negedge clk);
                chk("bp_valid", 64'(u_if.out_valid), 64'd1);
                chk("bp_sum", u_if.out_sum, hs);
                chk("bp_addr", 64'(rom_addr), 64'(ha));
            end
            @(posedge clk);
            #1 u_if.out_ready = 1'b1;
        end
        if (bstart) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_cond("done_wait", 0);
        chk("done", 64'(done), 64'd1);
        chk("busy", 64'(busy), 64'd0);
        chk("found", 64'(found), 64'(v.f));
        if (v.f) chk("result", result, v.res);
        chk("pass_count", 64'(pass_count), 64'(v.pc));
        chk("rom_addr", 64'(rom_addr), 64'(v.ad));
        chk("sb_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        u_if.out_ready = 1'b1;
        tbl[0] = mk(64'sd1, -64'sd2, 64'sd3, 64'sd1,
                    7, 1'b1, 64'sd2, 16'd1, 16'd2);
        tbl[1] = mk(64'sd1, -64'sd1, 64'sd1, -64'sd1,
                    3, 1'b1, 64'sd0, 16'd0, 16'd2);
        tbl[2] = mk(64'sd3, 64'sd3, -64'sd4, -64'sd2,
                    5, 1'b1, 64'sd0, 16'd1, 16'd0);
        tbl[3] = mk(64'sd1, 64'sd1, 64'sd1, 64'sd1,
                    13, 1'b0, 64'sd0, 16'd3, 16'd0);
        tbl[4] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'sd1, -64'sd1, 64'sd0,
                    4, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 16'd0, 16'd3);
        for (int i = 0; i < 4; i++) rom_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_valid", 64'(u_if.out_valid), 64'd0);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_result", result, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i == 0, 1'b0);

        load(tbl[3]);
        pulse_start();
        wait_cond("wrap_pre", 2);
        chk("pre_wrap_pc", 64'(pass_count), 64'd0);
        wait_cond("wrap_wait", 3);
        chk("wrap_addr", 64'(rom_addr), 64'd0);
        chk("wrap_pc", 64'(pass_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_found", 64'(found), 64'd0);
        chk("arst_valid", 64'(u_if.out_valid), 64'd0);
        chk("arst_rom_en", 64'(rom_en), 64'd0);
        chk("arst_addr", 64'(rom_addr), 64'd0);
        chk("arst_pc", 64'(pass_count), 64'd0);
        chk("arst_result", result, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_vec(tbl[0], 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/day01_sweep_ctrl.md
Name: day01_sweep_ctrl

Overview:
- Sequencer for the day-01 frequency datapath.
- Repeatedly sweeps the input ROM and accumulates a running signed sum.
- Streams every intermediate sum, starting with the seed value 0, to a downstream "seen-set" checker over a valid/ready handshake.
- Stops on the first sum the checker flags as a repeat, or when a pass limit is reached. This is the control core for part 2; the checker is a separate block.

Parameters:
- ROM_DEPTH, 973: number of ROM entries swept per pass (addresses 0..ROM_DEPTH-1).
- ADDR_W, 16: ROM address width.
- DATA_W, 64: signed data, sum and result width.
- MAX_PASSES, 1024: number of full passes after which the search aborts; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a search.
- rom_addr  out  ADDR_W  ROM address.
- rom_en  out  1  ROM enable.
- rom_data  in  DATA_W  signed ROM word; combinational from rom_addr, valid in the same cycle.
- out_valid  out  1  candidate sum presented to the checker.
- out_ready  in  1  checker accepts the candidate.
- out_sum  out  DATA_W  candidate sum.
- resp_valid  in  1  checker verdict strobe for the last accepted candidate.
- resp_hit  in  1  verdict: candidate was already seen.
- busy  out  1  search in progress.
- done  out  1  search finished; held until next start.
- found  out  1  valid when done: 1 = repeat found, 0 = pass limit hit.
- result  out  DATA_W  first repeated sum; valid when done & found.
- pass_count  out  16  number of completed full sweeps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rom_addr=0; internal sum=0; pass_count=0.
  - busy, done, found, out_valid, rom_en = 0; result=0.
- States: IDLE, SEED, ISSUE, WAIT_RESP, DONE.
- IDLE or DONE + start:
  - Next state SEED; sum=0; rom_addr=0; pass_count=0.
  - done=0, found=0, busy=1.
  - result holds its old value until overwritten.
- start while busy: ignored.
- SEED:
  - out_valid=1, out_sum=0.
  - On out_valid & out_ready: go to WAIT_RESP. rom_addr is not advanced.
- ISSUE:
  - out_valid=1, out_sum = sum + rom_data (combinational; two's-complement wrap at DATA_W, no saturation).
  - On handshake:
    - sum <= out_sum.
    - If rom_addr==ROM_DEPTH-1: rom_addr <= 0 and pass_count++. Otherwise rom_addr++.
    - Go to WAIT_RESP.
- Backpressure: while out_valid & !out_ready, out_sum and rom_addr must stay stable.
- WAIT_RESP:
  - out_valid=0.
  - On resp_valid & resp_hit: result <= sum, found <= 1, go to DONE.
  - On resp_valid & !resp_hit:
    - If pass_count == MAX_PASSES: found <= 0, go to DONE.
    - Otherwise go to ISSUE.
- Outstanding items: exactly one candidate is outstanding at a time. resp_valid outside WAIT_RESP is ignored.
  - Minimum throughput: one candidate per 2 cycles when the checker answers on the cycle after acceptance.
- DONE: busy=0, done=1; rom_addr, sum and pass_count are held.
- rom_en = busy.
- pass_count saturates at 16'hFFFF.
- The pass-limit check happens only after the verdict. A hit on the last candidate of the final pass therefore wins: found=1.
- Reset mid-operation aborts immediately to the reset values; no partial handshake completes.

Test Plan:
- ROM_DEPTH=4, data {+1,-2,+3,+1}, start:
  - Accepted out_sum sequence 0,1,-1,2,3,4,2.
  - Checker flags the 7th item → done=1, found=1, result=2, pass_count=1.
- ROM_DEPTH=2, data {+1,-1}:
  - Sequence 0,1,0 → result=0, found=1, pass_count=1 (the seed counts as seen).
- ROM_DEPTH=5, data {+3,+3,+4,-2,-4}:
  - result=10, found=1.
  - Verify rom_addr wraps 4→0 and pass_count increments exactly at the wrap.
- ROM_DEPTH=2, data {+1,+1}, MAX_PASSES=3:
  - No hits; 7 candidates 0..6 are accepted.
  - Then done=1, found=0, pass_count=3.
- Backpressure: hold out_ready=0 for 5 cycles during ISSUE.
  - out_valid stays 1; out_sum and rom_addr stay constant.
  - The sum advances only once.
- Reset and restart:
  - Assert rst_n=0 in WAIT_RESP mid-pass → all outputs return to reset values asynchronously.
  - Then start → sequence restarts at 0.
  - Also check that start pulsed while busy has no effect.
